spi_receptor: RTL
=================

Name: spi_receptor

Overview:
- SPI slave (receiver end) that pairs with the team's SPI master transmitter.
- Oversamples the master's SCK, CS and MOSI on the local system clock.
- Supports all four modes, selected by CKP and CPH.
- Deserializes WIDTH-bit words from MOSI and simultaneously serializes a local TX word onto MISO, MSB first. Sits on the peripheral side of the SPI link and hands received words to local logic with a one-cycle valid strobe.

Parameters:
- WIDTH, 16: bits per SPI word; shift registers and bit counter are sized from it.
- SYNC_STAGES, 2: flip-flop depth of the input synchronizers on SCK, CS and MOSI (minimum 2).

Ports:
- CLK  input  1  system clock; all state updates on its rising edge.
- RESET  input  1  synchronous, active-high reset.
- CKP  input  1  clock polarity; 0 = SCK idles low, 1 = SCK idles high.
- CPH  input  1  clock phase; 0 = sample on leading edge, 1 = sample on trailing edge.
- SCK  input  1  serial clock from master; asynchronous to CLK.
- CS  input  1  chip select from master, active low; asynchronous.
- MOSI  input  1  serial data from master; asynchronous.
- TX_DATA  input  WIDTH  word to send to master; loaded at frame start and at each word boundary.
- MISO  output  1  serial data to master.
- RX_DATA  output  WIDTH  last complete word received; held until the next complete word.
- RX_VALID  output  1  one-CLK pulse when RX_DATA updates.
- BUSY  output  1  high while the synchronized CS is low.
- FRAME_ERR  output  1  one-CLK pulse when CS deasserts mid-word.

Behaviour:
- Reset (RESET=1 at a CLK edge):
  - CS synchronizer stages set to 1; SCK and MOSI stages set to 0.
  - Shift registers, bit counter, latched mode, RX_DATA, RX_VALID, FRAME_ERR, MISO and BUSY all set to 0.
  - Reset mid-frame aborts the frame with no RX_VALID and no FRAME_ERR. After reset, the block waits for a fresh CS falling edge.
- Synchronization: SCK, CS and MOSI each pass through SYNC_STAGES flip-flops. Edge detection compares the last synchronizer stage with one extra delayed stage. MOSI uses the same depth, so it stays aligned with SCK.
- Timing constraint: each SCK half-period and the CS-to-first-edge time must be at least 4 CLK cycles. Behaviour is undefined otherwise.
- States: IDLE, ACTIVE.
  - IDLE -> ACTIVE on a synchronized CS falling edge. On that edge:
    - latch {CKP, CPH} into the mode register;
    - load TX_DATA into the TX shift register;
    - clear the bit counter.
  - ACTIVE -> IDLE on a synchronized CS rising edge.
  - CKP/CPH changes while ACTIVE are ignored until the next frame.
- Edge roles, using the latched mode:
  - Sample edge is the rising SCK edge when CKP==CPH (modes 0 and 3), and the falling edge otherwise (modes 1 and 2).
  - Shift edge is the opposite SCK edge.
  - SCK edges in IDLE are ignored.
- Sample edge:
  - RX shift register <= {RX[WIDTH-2:0], MOSI_sync}.
  - Bit counter +1.
  - When the counter reaches WIDTH-1 → WIDTH:
    - RX_DATA <= completed word and RX_VALID pulses for 1 cycle, both registered on the same CLK edge that captures the last bit;
    - bit counter wraps to 0;
    - TX shift register reloads from TX_DATA.
- Shift edge: TX shift register shifts left by one only if at least one bit has been sampled in the current word (counter != 0). This skips the leading edge in CPH=1 modes.
- MISO = TX shift register MSB while ACTIVE; 0 in IDLE (no tri-state).
- Back-to-back words: CS held low for more than WIDTH sample edges produces consecutive words, each with its own RX_VALID.
- CS rising with counter != 0: FRAME_ERR pulses 1 cycle and the partial word is discarded (RX_DATA unchanged). CS rising with counter == 0: no error.
- BUSY = inverse of the last CS synchronizer stage.
- Latency: RX_VALID rises SYNC_STAGES+1 CLK edges after the raw SCK sample edge that completes the word.

Test Plan:
- Mode 0 (CKP=0, CPH=0), TX_DATA=16'hA5C3, master sends 16'h0605 with SCK half-period of 4 CLK → one RX_VALID pulse, RX_DATA=16'h0605, MISO bit stream at master sample edges = A5C3 MSB first, BUSY high during frame.
- Modes 1, 2 and 3, same words → identical RX_DATA and MISO streams. In CPH=1 the first (leading) edge must not shift MISO: first MISO bit seen is 1 (A5C3 MSB).
- Back-to-back: CS low for 32 sample edges, MOSI=16'h1234 then 16'hBEEF, TX_DATA changed to 16'h00FF after first RX_VALID → two RX_VALID pulses with RX_DATA 1234 then BEEF; second MISO word = 00FF.
- Early abort: CS rises after 7 sample edges → FRAME_ERR pulses once, no RX_VALID, RX_DATA keeps previous value. The next full frame is received correctly.
- Mode change mid-frame: CKP toggled while CS low → current word still decoded with the latched mode. The new mode takes effect only on the next CS fall.
- Reset mid-frame: RESET=1 for 1 cycle after 9 bits → all outputs 0 the next cycle. The remaining SCK edges produce no RX_VALID or FRAME_ERR until CS rises and falls again.

Source files
------------

// File: rtl/spi_receptor.sv
// SPI slave receiver: oversamples SCK/CS/MOSI on CLK, deserializes WIDTH-bit words
// from MOSI and serializes a local TX word onto MISO, MSB first, in any of the four SPI modes.
module spi_receptor #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CKP,
  input  logic             CPH,
  input  logic             SCK,
  input  logic             CS,
  input  logic             MOSI,
  input  logic [WIDTH-1:0] TX_DATA,
  output logic             MISO,
  output logic [WIDTH-1:0] RX_DATA,
  output logic             RX_VALID,
  output logic             BUSY,
  output logic             FRAME_ERR
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state_reg, state_next;

  logic [SYNC_STAGES-1:0] sck_sync_reg, cs_sync_reg, mosi_sync_reg;
  logic                   sck_dly_reg, cs_dly_reg;
  logic [SYNC_STAGES:0]   primed_reg;

  logic [1:0]       mode_reg;
  logic [WIDTH-1:0] tx_shift_reg;
  logic [WIDTH-2:0] rx_shift_reg;
  logic [CNT_W-1:0] bit_cnt_reg;
  logic [WIDTH-1:0] rx_data_reg;
  logic             rx_valid_reg, frame_err_reg;

  logic             sck_last, cs_last, mosi_last, primed;
  logic             sck_rise, sck_fall, cs_rise, cs_fall;
  logic             sample_on_rise, sample_edge, shift_edge;
  logic [WIDTH-1:0] rx_word;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sck_sync_reg  <= '0;
      cs_sync_reg   <= '1;
      mosi_sync_reg <= '0;
      sck_dly_reg   <= 1'b0;
      cs_dly_reg    <= 1'b1;
      primed_reg    <= '0;
    end else begin
      sck_sync_reg  <= {sck_sync_reg[SYNC_STAGES-2:0], SCK};
      cs_sync_reg   <= {cs_sync_reg[SYNC_STAGES-2:0], CS};
      mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], MOSI};
      sck_dly_reg   <= sck_sync_reg[SYNC_STAGES-1];
      cs_dly_reg    <= cs_sync_reg[SYNC_STAGES-1];
      primed_reg    <= {primed_reg[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign sck_last  = sck_sync_reg[SYNC_STAGES-1];
  assign cs_last   = cs_sync_reg[SYNC_STAGES-1];
  assign mosi_last = mosi_sync_reg[SYNC_STAGES-1];

  // Edges are only trusted once real samples have flushed the reset values out of
  // the chain; otherwise a CS held low through reset would look like a fresh fall.
  assign primed   = primed_reg[SYNC_STAGES];
  assign sck_rise = primed &  sck_last & ~sck_dly_reg;
  assign sck_fall = primed & ~sck_last &  sck_dly_reg;
  assign cs_rise  = primed &  cs_last  & ~cs_dly_reg;
  assign cs_fall  = primed & ~cs_last  &  cs_dly_reg;

  assign sample_on_rise = (mode_reg[1] == mode_reg[0]);
  assign sample_edge    = (state_reg == ACTIVE) & (sample_on_rise ? sck_rise : sck_fall);
  assign shift_edge     = (state_reg == ACTIVE) & (sample_on_rise ? sck_fall : sck_rise);
  assign rx_word        = {rx_shift_reg, mosi_last};

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (cs_fall) state_next = ACTIVE;
      ACTIVE:  if (cs_rise) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      mode_reg      <= '0;
      tx_shift_reg  <= '0;
      rx_shift_reg  <= '0;
      bit_cnt_reg   <= '0;
      rx_data_reg   <= '0;
      rx_valid_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      rx_valid_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
      if (state_reg == IDLE) begin
        if (cs_fall) begin
          mode_reg     <= {CKP, CPH};
          tx_shift_reg <= TX_DATA;
          rx_shift_reg <= '0;
          bit_cnt_reg  <= '0;
        end
      end else if (cs_rise) begin
        // A partial word is dropped; only the error strobe reports it.
        frame_err_reg <= (bit_cnt_reg != '0);
        bit_cnt_reg   <= '0;
      end else if (sample_edge) begin
        rx_shift_reg <= rx_word[WIDTH-2:0];
        if (bit_cnt_reg == LAST_BIT) begin
          rx_data_reg  <= rx_word;
          rx_valid_reg <= 1'b1;
          bit_cnt_reg  <= '0;
          tx_shift_reg <= TX_DATA;
        end else begin
          bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
        end
      end else if (shift_edge && (bit_cnt_reg != '0)) begin
        tx_shift_reg <= {tx_shift_reg[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign MISO      = (state_reg == ACTIVE) & tx_shift_reg[WIDTH-1];
  assign RX_DATA   = rx_data_reg;
  assign RX_VALID  = rx_valid_reg;
  assign FRAME_ERR = frame_err_reg;
  assign BUSY      = ~cs_last;

endmodule
